// File: rtl/palette_pkg.sv
// Shared palette types and the 16-entry sprite colour table.
// Optional transparency keying is selected in palette_arbiter via PALETTE_TRANSPARENCY_EN.
package palette_pkg;

    localparam int unsigned PAL_IDX_W = 4;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam logic [15:0] TRANSPARENT_KEY = 16'h0E3B;

    localparam rgb565_t PALETTE [0:15] = '{
        '{5'd1,  6'd49, 5'd27},
        '{5'd0,  6'd0,  5'd0 },
        '{5'd3,  6'd7,  5'd0 },
        '{5'd30, 6'd61, 5'd30},
        '{5'd19, 6'd17, 5'd7 },
        '{5'd9,  6'd5,  5'd0 },
        '{5'd27, 6'd25, 5'd10},
        '{5'd15, 6'd11, 5'd0 },
        '{5'd24, 6'd17, 5'd0 },
        '{5'd30, 6'd33, 5'd13},
        '{5'd30, 6'd47, 5'd18},
        '{5'd30, 6'd61, 5'd11},
        '{5'd30, 6'd35, 5'd30},
        '{5'd30, 6'd19, 5'd23},
        '{5'd12, 6'd5,  5'd8 },
        '{5'd22, 6'd11, 5'd15}
    };

endpackage

// File: rtl/palette_rom.sv
// Combinational 4-bit index to RGB565 lookup over the package palette table.
module palette_rom
    import palette_pkg::*;
(
    input  logic [PAL_IDX_W-1:0] idx_i,
    output rgb565_t              rgb_o
);

    always_comb begin
        rgb_o = PALETTE[idx_i];
    end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin arbiter sharing one palette ROM among N_REQ sprite requesters, with a registered
// valid/ready output stage. Define PALETTE_TRANSPARENCY_EN to flag index 0 as the transparent key.
module palette_arbiter
    import palette_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [PAL_IDX_W*N_REQ-1:0] req_index_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ID_W-1:0]          out_id_o,
    output logic [15:0]              out_rgb_o,
    output logic                     out_transparent_o
);

    logic                 out_valid_q, out_valid_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    rgb565_t              out_rgb_q, out_rgb_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 slot_free;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      cand_id;
    logic                 transfer;
    logic [PAL_IDX_W-1:0] sel_index;
    rgb565_t              rom_rgb;

    assign slot_free = !out_valid_q || out_ready_i;

    // First valid requester after the last granted one, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_id = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_found && req_valid_i[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    assign transfer    = slot_free && grant_found && !rst_i;
    assign req_ready_o = transfer ? (N_REQ'(1) << grant_id) : '0;
    assign sel_index   = req_index_i[32'(grant_id)*PAL_IDX_W +: PAL_IDX_W];

    palette_rom u_rom (
        .idx_i (sel_index),
        .rgb_o (rom_rgb)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_rgb_d   = out_rgb_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_id_d    = grant_id;
            out_rgb_d   = rom_rgb;
            rr_ptr_d    = grant_id;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_rgb_q   <= '0;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_rgb_q   <= out_rgb_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef PALETTE_TRANSPARENCY_EN
    logic trans_q, trans_d;

    always_comb begin
        trans_d = trans_q;
        if (transfer) begin
            trans_d = (sel_index == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trans_q <= 1'b0;
        end else begin
            trans_q <= trans_d;
        end
    end

    assign out_transparent_o = trans_q;
`else
    assign out_transparent_o = 1'b0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_id_o    = out_id_q;
    assign out_rgb_o   = out_rgb_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter: per-cycle comparison against a behavioural model plus
// hand-computed literal checks. Honours PALETTE_TRANSPARENCY_EN when defined.
module tb_palette_arbiter;

    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] req_valid_i;
    logic [4*N-1:0] req_index_i;
    logic [N-1:0] req_ready_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [1:0]   out_id_o;
    logic [15:0]  out_rgb_o;
    logic         out_transparent_o;

    int n_cmp = 0;
    int n_bad = 0;

    palette_arbiter #(.N_REQ(N)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_index_i       (req_index_i),
        .req_ready_o       (req_ready_o),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_id_o          (out_id_o),
        .out_rgb_o         (out_rgb_o),
        .out_transparent_o (out_transparent_o)
    );

    always #5 clk_i = ~clk_i;

    // Palette given as {R,G,B} triples; packed into RGB565 arithmetically.
    int pal_r [16] = '{1, 0, 3, 30, 19, 9, 27, 15, 24, 30, 30, 30, 30, 30, 12, 22};
    int pal_g [16] = '{49, 0, 7, 61, 17, 5, 25, 11, 17, 33, 47, 61, 35, 19, 5, 11};
    int pal_b [16] = '{27, 0, 0, 30, 7, 0, 10, 0, 0, 13, 18, 11, 30, 23, 8, 15};

    function automatic int rgb_of(input int idx);
        return pal_r[idx] * 2048 + pal_g[idx] * 32 + pal_b[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: committed on the clock, next values prepared on the falling edge.
    int m_valid, m_id, m_rgb, m_tr, m_ptr;
    int n_valid, n_id, n_rgb, n_tr, n_ptr;
    bit nxt_ok = 1'b0;

    always @(negedge clk_i) begin
        int g;
        int idx;
        logic [N-1:0] exp_ready;
        if (rst_i) begin
            nxt_ok <= 1'b0;
        end else begin
            g = -1;
            if (m_valid == 0 || out_ready_i) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && req_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("model_req_ready", 32'(req_ready_o), 32'(exp_ready));
            check("model_out_valid", 32'(out_valid_o), m_valid);
            if (m_valid != 0) begin
                check("model_out_id", 32'(out_id_o), m_id);
                check("model_out_rgb", 32'(out_rgb_o), m_rgb);
                check("model_out_transparent", 32'(out_transparent_o), m_tr);
            end
            n_valid <= m_valid;
            n_id    <= m_id;
            n_rgb   <= m_rgb;
            n_tr    <= m_tr;
            n_ptr   <= m_ptr;
            if (g >= 0) begin
                idx = int'(req_index_i[4*g +: 4]);
                n_valid <= 1;
                n_id    <= g;
                n_rgb   <= rgb_of(idx);
`ifdef PALETTE_TRANSPARENCY_EN
                n_tr    <= (idx == 0) ? 1 : 0;
`else
                n_tr    <= 0;
`endif
                n_ptr   <= g;
            end else if (out_ready_i) begin
                n_valid <= 0;
            end
            nxt_ok <= 1'b1;
        end
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valid <= 0;
            m_id    <= 0;
            m_rgb   <= 0;
            m_tr    <= 0;
            m_ptr   <= N - 1;
        end else if (nxt_ok) begin
            m_valid <= n_valid;
            m_id    <= n_id;
            m_rgb   <= n_rgb;
            m_tr    <= n_tr;
            m_ptr   <= n_ptr;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v, input logic [3:0] i3, input logic [3:0] i2,
                           input logic [3:0] i1, input logic [3:0] i0);
        req_valid_i = v;
        req_index_i = {i3, i2, i1, i0};
    endtask

    initial begin
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        set_req(4'b1111, 4'd4, 4'd3, 4'd2, 4'd6);

        // Reset with every requester pending.
        step();
        step();
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_out_rgb", 32'(out_rgb_o), 32'd0);
        check("rst_out_id", 32'(out_id_o), 32'd0);
        check("rst_out_transparent", 32'(out_transparent_o), 32'd0);
        #1 rst_i = 1'b0;
        #1 check("first_grant_req0", 32'(req_ready_o), 32'b0001);
        step();
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        check("first_out_id", 32'(out_id_o), 32'd0);
        check("first_out_rgb_idx6", 32'(out_rgb_o), 32'hDB2A);

        // Single request: requester 2, index 3.
        set_req(4'b0100, 4'd0, 4'd3, 4'd0, 4'd0);
        #1 check("single_req_ready", 32'(req_ready_o), 32'b0100);
        step();
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        check("single_out_valid", 32'(out_valid_o), 32'd1);
        check("single_out_id", 32'(out_id_o), 32'd2);
        check("single_out_rgb", 32'(out_rgb_o), 32'hF7BE);
        step();
        check("drain_out_valid", 32'(out_valid_o), 32'd0);

        // Move the pointer to 3 so the fairness run starts at requester 0.
        set_req(4'b1000, 4'd1, 4'd0, 4'd0, 4'd0);
        step();
        set_req(4'b1111, 4'd12, 4'd9, 4'd5, 4'd1);
        for (int k = 0; k < 8; k++) begin
            #1 check("fair_grant", 32'(req_ready_o), 32'(1 << (k % 4)));
            step();
        end
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        check("fair_last_id", 32'(out_id_o), 32'd3);
        check("fair_last_rgb_idx12", 32'(out_rgb_o), 32'hF47E);
        step();

        // Backpressure: hold requester 1's index-2 result for three cycles.
        set_req(4'b0010, 4'd0, 4'd0, 4'd2, 4'd0);
        step();
        out_ready_i = 1'b0;
        set_req(4'b0001, 4'd0, 4'd0, 4'd0, 4'd7);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
            check("bp_out_valid", 32'(out_valid_o), 32'd1);
            check("bp_out_id", 32'(out_id_o), 32'd1);
            check("bp_out_rgb", 32'(out_rgb_o), 32'h18E0);
            step();
        end
        out_ready_i = 1'b1;
        #1 check("bp_release_grant", 32'(req_ready_o), 32'b0001);
        step();
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        check("bp_next_id", 32'(out_id_o), 32'd0);
        check("bp_next_rgb", 32'(out_rgb_o), 32'h7960);

        // Index 0 from requester 1.
        set_req(4'b0010, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        check("tr_out_id", 32'(out_id_o), 32'd1);
        check("tr_out_rgb", 32'(out_rgb_o), 32'h0E3B);
`ifdef PALETTE_TRANSPARENCY_EN
        check("tr_flag", 32'(out_transparent_o), 32'd1);
`else
        check("tr_flag", 32'(out_transparent_o), 32'd0);
`endif
        step();

        // Reset while a result is held under backpressure.
        set_req(4'b0100, 4'd0, 4'd9, 4'd0, 4'd0);
        step();
        out_ready_i = 1'b0;
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1 check("mid_pre_valid", 32'(out_valid_o), 32'd1);
        check("mid_pre_rgb", 32'(out_rgb_o), 32'hF42D);
        #1 rst_i = 1'b1;
        #1 check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_rgb", 32'(out_rgb_o), 32'd0);
        step();
        step();
        set_req(4'b1111, 4'd3, 4'd3, 4'd3, 4'd3);
        out_ready_i = 1'b1;
        #1 rst_i = 1'b0;
        #1 check("mid_after_grant", 32'(req_ready_o), 32'b0001);
        step();
        set_req(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        check("mid_after_id", 32'(out_id_o), 32'd0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
